sync_event_arb: RTL and testbench

//  Front end for N_CH external inputs (buttons, straps, async lines) on the Fomu fabric.

---
 rtl/sync_event_arb_pkg.sv | 42 ++++
 rtl/clk_sync.sv | 19 +
 rtl/sync_debounce.sv | 57 +++++
 rtl/sync_event_arb.sv | 114 +++++++++++
 tb/tb_sync_event_arb.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_event_arb_pkg.sv
// Shared types and helpers for sync_event_arb: scheduler state encoding,
// channel-index width and the round-robin pick function.
package sync_event_arb_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requesting channel at or after ptr, wrapping at n. Scanning from the
    // far end lets the closest candidate overwrite the result last.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                n);
        rr_pick_t   res;
        logic [4:0] cand;
        res = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + 5'(i);
            if (cand >= 5'(n)) begin
                cand = cand - 5'(n);
            end
            if ((i < n) && req[cand[3:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_sync.sv
// Multi-flop synchronizer for one asynchronous line. No reset: the chain only
// carries the pin value and flushes itself within STAGES cycles.
module clk_sync #(
    parameter int STAGES = 3
) (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        sync_q <= {sync_q[STAGES-2:0], i_d};
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// One input channel: synchronizer, persistence counter and debounced level.
// o_event pulses combinationally in the cycle the new level is accepted.
module sync_debounce #(
    parameter int STAGES   = 3,
    parameter int DEBOUNCE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_event,
    output logic o_edge
);

    localparam int              CNT_W    = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             synced;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;
    logic             accept;

    clk_sync #(.STAGES(STAGES)) u_sync (
        .i_clk (i_clk),
        .i_d   (i_raw),
        .o_q   (synced)
    );

    assign differ = (synced != level_q);
    assign accept = differ && (cnt_q == CNT_LAST);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (accept) begin
            level_d = synced;
        end else if (differ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_event = accept;
    assign o_edge  = synced;

endmodule

// File: rtl/sync_event_arb.sv
// Debounced multi-channel event front end with a round-robin valid/ready output.
// Define SYNC_EVENT_FALL_EN to report falling edges too; otherwise only presses.
module sync_event_arb
    import sync_event_arb_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int STAGES   = 3,
    parameter int DEBOUNCE = 16,
    localparam int CH_W    = ch_width(N_CH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_ext,
    output logic [N_CH-1:0] o_level,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [CH_W-1:0] o_chan,
    output logic            o_edge,
    output logic [N_CH-1:0] o_overrun,
    input  logic            i_ovr_clr
);

`ifdef SYNC_EVENT_FALL_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic [N_CH-1:0]   db_event, db_edge, raise, load_hit;
    logic [N_CH-1:0]   pend_q, pend_d, pend_edge_q, pend_edge_d, ovr_q, ovr_d;
    logic [MAX_CH-1:0] pend_edge_all;
    sched_state_t      state_q;
    logic [CH_W-1:0]   chan_q, rr_q, next_ptr, base_ptr;
    logic              edge_q;
    logic              xfer, load;
    rr_pick_t          pick;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        sync_debounce #(
            .STAGES   (STAGES),
            .DEBOUNCE (DEBOUNCE)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_ext[gi]),
            .o_level (o_level[gi]),
            .o_event (db_event[gi]),
            .o_edge  (db_edge[gi])
        );

        // A raise beats a same-cycle load; only a raise onto an unloaded pending slot overruns.
        assign raise[gi]       = db_event[gi] & (FALL_EN | db_edge[gi]);
        assign load_hit[gi]    = load && (pick.idx == 4'(gi));
        assign pend_d[gi]      = raise[gi] | (pend_q[gi] & ~load_hit[gi]);
        assign pend_edge_d[gi] = raise[gi] ? db_edge[gi] : pend_edge_q[gi];
        assign ovr_d[gi]       = (raise[gi] & pend_q[gi] & ~load_hit[gi]) | (ovr_q[gi] & ~i_ovr_clr);
    end

    assign next_ptr      = (chan_q == CH_W'(N_CH - 1)) ? '0 : chan_q + CH_W'(1);
    assign base_ptr      = (state_q == ST_PRESENT) ? next_ptr : rr_q;
    assign pick          = rr_pick(MAX_CH'(pend_q), 4'(base_ptr), N_CH);
    assign pend_edge_all = MAX_CH'(pend_edge_q);
    assign xfer          = (state_q == ST_PRESENT) && i_ready;
    assign load          = pick.found && ((state_q == ST_IDLE) || xfer);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q      <= '0;
            pend_edge_q <= '0;
            ovr_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_edge_q <= pend_edge_d;
            ovr_q       <= ovr_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            edge_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        chan_q  <= CH_W'(pick.idx);
                        edge_q  <= pend_edge_all[pick.idx];
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_ready) begin
                        rr_q <= next_ptr;
                        if (load) begin
                            chan_q <= CH_W'(pick.idx);
                            edge_q <= pend_edge_all[pick.idx];
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_valid   = (state_q == ST_PRESENT);
    assign o_chan    = chan_q;
    assign o_edge    = FALL_EN ? edge_q : 1'b1;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_sync_event_arb.sv
// Bench for sync_event_arb (N_CH=4, STAGES=3, DEBOUNCE=4) with a cycle model
// built from window-based debounce and round-robin delivery rules.
module tb_sync_event_arb;

    localparam int N  = 4;
    localparam int ST = 3;
    localparam int DB = 4;
`ifdef SYNC_EVENT_FALL_EN
    localparam bit FALL = 1'b1;
`else
    localparam bit FALL = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] ext     = 4'b0000;
    logic       ready   = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [3:0] level;
    logic       valid;
    logic [1:0] chan;
    logic       edge_o;
    logic [3:0] ovr;

    sync_event_arb #(.N_CH(N), .STAGES(ST), .DEBOUNCE(DB)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ext     (ext),
        .o_level   (level),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_chan    (chan),
        .o_edge    (edge_o),
        .o_overrun (ovr),
        .i_ovr_clr (ovr_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] hist[$];
    int         rel = 0;
    bit         m_lvl[N], m_pend[N], m_pedge[N], m_ovr[N];
    bit         m_pres, m_pedg;
    int         m_ch, m_rr;
    int         obs_ch[$];
    bit         obs_edge[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit synced_at(input int t, input int c);
        if (t - ST < 0) return 1'b0;
        return hist[t - ST][c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_lvl[c] = 0; m_pend[c] = 0; m_pedge[c] = 0; m_ovr[c] = 0;
        end
        m_pres = 0; m_pedg = 0; m_ch = 0; m_rr = 0;
    endtask

    // Reference: a level flips once the last DB synced samples since reset all
    // disagree with it; pending slots hold the newest edge; delivery is RR.
    task automatic model_edge();
        int t, base, sel;
        bit raise[N];
        bit nv[N];
        bit xfer, load, all_eq;
        hist.push_back(ext);
        t = hist.size() - 1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            raise[c] = 0;
            nv[c]    = !m_lvl[c];
            if (t - DB + 1 >= rel) begin
                all_eq = 1;
                for (int k = 0; k < DB; k++) if (synced_at(t - k, c) != nv[c]) all_eq = 0;
                if (all_eq) begin
                    m_lvl[c] = nv[c];
                    raise[c] = FALL || nv[c];
                end
            end
        end
        xfer = m_pres && ready;
        load = 0;
        sel  = 0;
        if (!m_pres || xfer) begin
            base = m_pres ? (m_ch + 1) % N : m_rr;
            for (int off = 0; off < N; off++) begin
                if (m_pend[(base + off) % N]) begin
                    sel  = (base + off) % N;
                    load = 1;
                    break;
                end
            end
        end
        if (xfer) m_rr = (m_ch + 1) % N;
        if (load) begin
            m_pres = 1; m_ch = sel; m_pedg = m_pedge[sel];
        end else if (xfer) begin
            m_pres = 0;
        end
        for (int c = 0; c < N; c++) begin
            bit ld, setov;
            ld    = load && (sel == c);
            setov = raise[c] && m_pend[c] && !ld;
            if (raise[c]) begin
                m_pend[c] = 1; m_pedge[c] = nv[c];
            end else if (ld) begin
                m_pend[c] = 0;
            end
            m_ovr[c] = setov ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr[c]);
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_lvl, e_ovr;
        for (int c = 0; c < N; c++) begin
            e_lvl[c] = m_lvl[c];
            e_ovr[c] = m_ovr[c];
        end
        check("level", 32'(level), 32'(e_lvl));
        check("valid", 32'(valid), 32'(m_pres));
        if (m_pres) begin
            check("chan", 32'(chan), 32'(m_ch));
            check("edge", 32'(edge_o), FALL ? 32'(m_pedg) : 32'd1);
        end
        check("overrun", 32'(ovr), 32'(e_ovr));
    endtask

    task automatic step();
        if (valid === 1'b1 && ready) begin
            obs_ch.push_back(int'(chan));
            obs_edge.push_back(edge_o);
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        rel   = hist.size();
    endtask

    int lvl_cyc, val_cyc, cyc;
    bit rose;
    int exp_a[4] = '{2, 3, 0, 1};
    int exp_d[4] = '{0, 1, 2, 3};

    initial begin
        model_reset();
        // Reset state
        steps(6);
        check("rst_chan", 32'(chan), 32'd0);
        check("rst_edge", 32'(edge_o), FALL ? 32'd0 : 32'd1);
        release_reset();
        steps(10);

        // Single press on ch2: level at cycle 7, valid at cycle 8
        ext[2] = 1'b1;
        lvl_cyc = 0; val_cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (level[2] === 1'b1 && lvl_cyc == 0) lvl_cyc = n;
            if (valid === 1'b1 && val_cyc == 0) val_cyc = n;
        end
        check("press_level_cycle", 32'(lvl_cyc), 32'd7);
        check("press_valid_cycle", 32'(val_cyc), 32'd8);
        check("press_chan", 32'(chan), 32'd2);
        check("press_edge", 32'(edge_o), 32'd1);
        ready = 1'b1;
        step();
        ext[2] = 1'b0;
        steps(12);

        // Glitches on ch1: 3 cycles rejected, 4 cycles accepted
        rose = 0;
        ext[1] = 1'b1; steps(3); ext[1] = 1'b0;
        for (int n = 0; n < 12; n++) begin step(); if (level[1] === 1'b1) rose = 1; end
        check("glitch3_level", 32'(rose), 32'd0);
        rose = 0;
        ext[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin step(); if (level[1] === 1'b1) rose = 1; end
        ext[1] = 1'b0;
        for (int n = 0; n < 15; n++) begin step(); if (level[1] === 1'b1) rose = 1; end
        check("glitch4_level", 32'(rose), 32'd1);

        // Simultaneous presses, RR pointer at 2
        obs_ch.delete(); obs_edge.delete();
        ext = 4'b1111; steps(15);
        check("burst_a_count", 32'(obs_ch.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_ch.size(); i++) check($sformatf("burst_a_ch%0d", i), 32'(obs_ch[i]), 32'(exp_a[i]));
        ext = 4'b0000; steps(15);
        ext = 4'b1000; steps(15);
        ext = 4'b0000; steps(15);
        // Simultaneous presses, RR pointer at 0
        obs_ch.delete(); obs_edge.delete();
        ext = 4'b1111; steps(15);
        check("burst_d_count", 32'(obs_ch.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_ch.size(); i++) check($sformatf("burst_d_ch%0d", i), 32'(obs_ch[i]), 32'(exp_d[i]));
        ext = 4'b0000; steps(15);

        // Overrun on ch0 while the consumer stalls
        ready = 1'b0;
        for (int seg = 0; seg < 5; seg++) begin
            ext[0] = (seg % 2 == 0);
            steps(10);
        end
        check("ovr_held_chan", 32'(chan), 32'd0);
        check("ovr_held_edge", 32'(edge_o), 32'd1);
        check("ovr_set", 32'(ovr[0]), 32'd1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        check("ovr_clr", 32'(ovr), 32'd0);
        obs_ch.delete(); obs_edge.delete();
        ready = 1'b1; steps(15);
        check("ovr_drain_count", 32'(obs_ch.size()), 32'd2);
        if (obs_ch.size() >= 2) begin
            check("ovr_latest_ch", 32'(obs_ch[1]), 32'd0);
            check("ovr_latest_edge", 32'(obs_edge[1]), 32'd1);
        end

        // Random traffic with backpressure and occasional overrun clears
        for (int i = 0; i < 600; i++) begin
            ready   = 1'($urandom_range(0, 1));
            ovr_clr = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < N; c++) if ($urandom_range(0, 9) == 0) ext[c] = ~ext[c];
            step();
        end
        ovr_clr = 1'b0;
        ready = 1'b1; ext = 4'b0000; steps(20);

        // Asynchronous reset while presenting
        ready = 1'b0; ext = 4'b0100;
        cyc = 0;
        for (int n = 1; n <= 20 && cyc == 0; n++) begin step(); if (valid === 1'b1) cyc = n; end
        check("pre_rst_valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("arst_valid", 32'(valid), 32'd0);
        steps(3);
        release_reset();
        cyc = 0;
        for (int n = 1; n <= 20 && cyc == 0; n++) begin step(); if (valid === 1'b1) cyc = n; end
        check("rerep_cycle", 32'(cyc), 32'(DB + 1));
        check("rerep_chan", 32'(chan), 32'd2);
        check("rerep_edge", 32'(edge_o), 32'd1);
        ready = 1'b1; steps(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
